// File: rtl/perf_counter_sampler.sv
// Periodic scanner for a performance-counter bank: on every timer tick it selects
// each counter in turn and streams (index, value, last) records over a ready/valid port.
module perf_counter_sampler #(
  parameter int COUNTER_WIDTH = 32,
  parameter int COUNTER_COUNT = 8,
  parameter int PERIOD_WIDTH  = 16,
  localparam int IDX_W = (COUNTER_COUNT > 1) ? $clog2(COUNTER_COUNT) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     stop,
  input  logic [PERIOD_WIDTH-1:0]  period,
  input  logic                     clear_on_sample,
  output logic                     pc_enable,
  output logic                     pc_clear,
  output logic [COUNTER_COUNT-1:0] pc_counter_sel,
  input  logic [COUNTER_WIDTH-1:0] pc_count_value,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [IDX_W-1:0]         out_index,
  output logic [COUNTER_WIDTH-1:0] out_value,
  output logic                     out_last,
  output logic                     busy,
  output logic                     overrun
);

  // state | meaning
  // IDLE  | not sampling, timer frozen
  // WAIT  | counting down to the next tick
  // CAP   | select counter idx and capture its value
  // OUT   | present record, wait for handshake
  // CLR   | one-cycle clear pulse to the bank
  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_CAP, S_OUT, S_CLR} state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(COUNTER_COUNT - 1);

  state_t                     state_q, state_d;
  logic [IDX_W-1:0]           idx_q, idx_d;
  logic [PERIOD_WIDTH-1:0]    timer_q, timer_d;
  logic                       run_q, run_d;
  logic                       overrun_q, overrun_d;
  logic [IDX_W-1:0]           out_index_q, out_index_d;
  logic [COUNTER_WIDTH-1:0]   out_value_q, out_value_d;
  logic                       out_last_q, out_last_d;

  logic [PERIOD_WIDTH-1:0]    reload;
  logic                       tick;
  logic                       stopping;
  logic                       is_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      timer_q     <= '0;
      run_q       <= 1'b0;
      overrun_q   <= 1'b0;
      out_index_q <= '0;
      out_value_q <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      timer_q     <= timer_d;
      run_q       <= run_d;
      overrun_q   <= overrun_d;
      out_index_q <= out_index_d;
      out_value_q <= out_value_d;
      out_last_q  <= out_last_d;
    end
  end

  always_comb begin
    reload   = (period == '0) ? '0 : period - PERIOD_WIDTH'(1);
    tick     = (state_q != S_IDLE) && run_q && (timer_q == '0);
    // a stop seen at any point of a scan lets the scan finish, then parks in IDLE
    stopping = stop || !run_q;
    is_last  = (idx_q == LAST_IDX);

    state_d     = state_q;
    idx_d       = idx_q;
    timer_d     = timer_q;
    run_d       = run_q;
    overrun_d   = overrun_q;
    out_index_d = out_index_q;
    out_value_d = out_value_q;
    out_last_d  = out_last_q;

    if ((state_q != S_IDLE) && run_q)
      timer_d = tick ? reload : timer_q - PERIOD_WIDTH'(1);
    if (stop)
      run_d = 1'b0;
    if (tick && (state_q inside {S_CAP, S_OUT, S_CLR}))
      overrun_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (start && !stop) begin
          state_d   = S_WAIT;
          timer_d   = reload;
          run_d     = 1'b1;
          overrun_d = 1'b0;
        end
      end
      S_WAIT: begin
        if (stopping) begin
          state_d = S_IDLE;
        end else if (tick) begin
          state_d = S_CAP;
          idx_d   = '0;
        end
      end
      S_CAP: begin
        out_index_d = idx_q;
        out_value_d = pc_count_value;
        out_last_d  = is_last;
        state_d     = S_OUT;
      end
      S_OUT: begin
        if (out_ready) begin
          if (!is_last) begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = S_CAP;
          end else if (clear_on_sample) begin
            state_d = S_CLR;
          end else begin
            state_d = stopping ? S_IDLE : S_WAIT;
          end
        end
      end
      S_CLR:   state_d = stopping ? S_IDLE : S_WAIT;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    pc_counter_sel = '0;
    if ((state_q == S_CAP) || (state_q == S_OUT))
      pc_counter_sel = COUNTER_COUNT'(1) << idx_q;
    pc_enable = run_q;
    pc_clear  = (state_q == S_CLR);
    out_valid = (state_q == S_OUT);
    busy      = (state_q != S_IDLE);
  end

  assign out_index = out_index_q;
  assign out_value = out_value_q;
  assign out_last  = out_last_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_perf_counter_sampler.sv
// Directed-phase bench for perf_counter_sampler with a random-valued counter bank;
// expected record timing and contents come from tick arithmetic over the sample period.
module tb_perf_counter_sampler;

  localparam int CW = 16;
  localparam int CN = 4;
  localparam int PW = 8;

  logic          clk, rst_n, start, stop, clear_on_sample, out_ready;
  logic [PW-1:0] period;
  logic          pc_enable, pc_clear, out_valid, out_last, busy, overrun;
  logic [CN-1:0] pc_counter_sel;
  logic [CW-1:0] pc_count_value, out_value;
  logic [1:0]    out_index;

  perf_counter_sampler #(.COUNTER_WIDTH(CW), .COUNTER_COUNT(CN), .PERIOD_WIDTH(PW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .period(period),
    .clear_on_sample(clear_on_sample), .pc_enable(pc_enable), .pc_clear(pc_clear),
    .pc_counter_sel(pc_counter_sel), .pc_count_value(pc_count_value),
    .out_valid(out_valid), .out_ready(out_ready), .out_index(out_index),
    .out_value(out_value), .out_last(out_last), .busy(busy), .overrun(overrun)
  );

  typedef struct {
    int          cyc;
    int          idx;
    logic [CW-1:0] val;
    logic        last;
    logic [CN-1:0] sel;
  } rec_t;

  rec_t        rq[$];
  int          cq[$];
  int          cyc = 0;
  int          clr_count = 0;
  int          clr_mark = 0;
  logic [CW-1:0] base [CN];
  int          checks = 0;
  int          failures = 0;
  int          s;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (pc_clear) clr_count <= clr_count + 1;
  end

  always @(negedge clk) begin
    if (out_valid && out_ready)
      rq.push_back('{cyc: cyc, idx: int'(out_index), val: out_value, last: out_last, sel: pc_counter_sel});
    if (pc_clear) cq.push_back(cyc);
  end

  // counter bank: each counter holds its base value until a clear pulse has been seen
  always_comb begin
    pc_count_value = '0;
    for (int i = 0; i < CN; i++)
      if (pc_counter_sel[i]) pc_count_value = (clr_count > clr_mark) ? '0 : base[i];
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic go_to(input int c);
    while (cyc < c) step(1);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    s = cyc + 1;
    step(1);
    start = 1'b0;
  endtask

  // stop is sampled on edge c
  task automatic stop_at(input int c);
    go_to(c - 1);
    stop = 1'b1;
    step(1);
    stop = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 100; i++) begin
      if (!busy) break;
      step(1);
    end
    chk("idle_timeout", busy, 0);
  endtask

  task automatic new_bases();
    for (int i = 0; i < CN; i++) base[i] = CW'($urandom_range(1, 16'hFFFF));
    clr_mark = clr_count;
  endtask

  // scan k after a start sampled on edge st: tick lands on st+p*(k+1), record i handshakes 1+2i later
  task automatic chk_scan(input int q0, input int st, input int p, input int k, input bit zero);
    for (int i = 0; i < CN; i++) begin
      if (q0 + i >= rq.size()) begin
        chk("rec_missing", rq.size(), q0 + i + 1);
      end else begin
        chk("rec_cyc",  rq[q0+i].cyc,  st + p * (k + 1) + 1 + 2 * i);
        chk("rec_idx",  rq[q0+i].idx,  i);
        chk("rec_val",  rq[q0+i].val,  zero ? '0 : base[i]);
        chk("rec_last", rq[q0+i].last, i == CN - 1);
        chk("rec_sel",  rq[q0+i].sel,  4'b0001 << i);
      end
    end
  endtask

  initial begin
    rst_n = 1'b1; start = 1'b0; stop = 1'b0; period = '0;
    clear_on_sample = 1'b0; out_ready = 1'b1;
    new_bases();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_pc_enable", pc_enable, 0);
    chk("rst_pc_clear", pc_clear, 0);
    chk("rst_sel", pc_counter_sel, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_overrun", overrun, 0);
    step(3);
    rst_n = 1'b1;
    step(2);

    // periodic scans, period 10, no clearing
    period = 8'd10;
    chk("pre_start_enable", pc_enable, 0);
    pulse_start();
    chk("start_enable", pc_enable, 1);
    chk("start_busy", busy, 1);
    stop_at(s + 3 * 10 + 9);
    chk("stop_enable", pc_enable, 0);
    wait_idle();
    step(25);
    chk("a_rec_count", rq.size(), 12);
    for (int k = 0; k < 3; k++) chk_scan(4 * k, s, 10, k, 1'b0);
    chk("a_overrun", overrun, 0);
    chk("a_no_clear", cq.size(), 0);

    // clear after each scan, counter 2 forced to 5
    rq.delete(); cq.delete();
    new_bases();
    base[2] = 16'd5;
    period = 8'd12;
    clear_on_sample = 1'b1;
    pulse_start();
    stop_at(s + 2 * 12 + 10);
    wait_idle();
    chk("b_rec_count", rq.size(), 8);
    chk_scan(0, s, 12, 0, 1'b0);
    chk_scan(4, s, 12, 1, 1'b1);
    chk("b_clr_count", cq.size(), 2);
    if (cq.size() == 2) begin
      chk("b_clr0_cyc", cq[0], s + 12 + 8);
      chk("b_clr1_cyc", cq[1], s + 24 + 8);
    end

    // back-pressure with period 4
    rq.delete(); cq.delete();
    new_bases();
    clear_on_sample = 1'b0;
    period = 8'd4;
    out_ready = 1'b0;
    pulse_start();
    go_to(s + 5);
    for (int i = 0; i < 20; i++) begin
      chk("c_hold_valid", out_valid, 1);
      chk("c_hold_idx", out_index, 0);
      chk("c_hold_val", out_value, base[0]);
      chk("c_hold_sel", pc_counter_sel, 4'b0001);
      step(1);
    end
    chk("c_overrun", overrun, 1);
    out_ready = 1'b1;
    step(12);
    stop_at(cyc + 1);
    wait_idle();
    chk("c_rec_whole_scans", rq.size() % CN, 0);
    chk("c_rec_some", rq.size() >= CN, 1);
    for (int j = 0; j < rq.size(); j++) begin
      chk("c_rec_idx", rq[j].idx, j % CN);
      chk("c_rec_val", rq[j].val, base[j % CN]);
      chk("c_rec_last", rq[j].last, (j % CN) == CN - 1);
    end

    // stop during OUT of idx 1
    rq.delete(); cq.delete();
    new_bases();
    period = 8'd10;
    pulse_start();
    chk("d_overrun_cleared", overrun, 0);
    stop_at(s + 10 + 4);
    chk("d_enable_off", pc_enable, 0);
    go_to(s + 10 + 9);
    chk("d_busy_off", busy, 0);
    step(30);
    chk("d_rec_count", rq.size(), 4);
    chk_scan(0, s, 10, 0, 1'b0);

    // period 0: tick every cycle
    rq.delete(); cq.delete();
    new_bases();
    period = 8'd0;
    pulse_start();
    go_to(s + 3);
    chk("e_overrun", overrun, 1);
    stop_at(s + 10);
    wait_idle();
    chk_scan(0, s, 1, 0, 1'b0);
    chk("e_whole_scans", rq.size() % CN, 0);
    start = 1'b1; stop = 1'b1;
    step(1);
    start = 1'b0; stop = 1'b0;
    chk("e_startstop_busy", busy, 0);
    chk("e_startstop_enable", pc_enable, 0);
    step(3);
    chk("e_startstop_busy2", busy, 0);

    // reset during OUT
    rq.delete(); cq.delete();
    new_bases();
    period = 8'd10;
    clear_on_sample = 1'b1;
    pulse_start();
    go_to(s + 10 + 1);
    chk("f_in_out", out_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("f_rst_valid", out_valid, 0);
    chk("f_rst_sel", pc_counter_sel, 0);
    chk("f_rst_busy", busy, 0);
    chk("f_rst_enable", pc_enable, 0);
    chk("f_rst_clear", pc_clear, 0);
    chk("f_rst_index", out_index, 0);
    chk("f_rst_value", out_value, 0);
    chk("f_rst_last", out_last, 0);
    step(2);
    rst_n = 1'b1;
    rq.delete();
    step(20);
    chk("f_no_rec", rq.size(), 0);
    chk("f_no_clear", cq.size(), 0);
    chk("f_idle", busy, 0);
    pulse_start();
    go_to(s + 10 + 9);
    chk_scan(0, s, 10, 0, 1'b0);
    chk("f_clr_count", cq.size(), 1);
    if (cq.size() == 1) chk("f_clr_cyc", cq[0], s + 10 + 8);
    stop_at(cyc + 1);
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/perf_counter_sampler.md
PERF_COUNTER_SAMPLER -- requirements
Module: perf_counter_sampler

Interface
REQ-001 SHALL have parameter COUNTER_WIDTH, default 32, width of each counter value.
REQ-002 SHALL have parameter COUNTER_COUNT, default 8, number of counters scanned; IDX_W = max(1, clog2(COUNTER_COUNT)).
REQ-003 SHALL have parameter PERIOD_WIDTH, default 16, width of the sample-period register.
REQ-004 SHALL use a single clock and an asynchronous, active-low reset: clk is the one clock and rst_n is the reset, asynchronous and active-low.
REQ-005 clk  input  1  sole clock; all state on rising edge.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 start  input  1  one-cycle request to begin periodic sampling.
REQ-008 stop  input  1  one-cycle request to end sampling.
REQ-009 period  input  PERIOD_WIDTH  cycles between sample ticks; sampled on start and on every reload.
REQ-010 clear_on_sample  input  1  clear all counters after a completed scan.
REQ-011 pc_enable  output  1  enable for the performance counter bank.
REQ-012 pc_clear  output  1  one-cycle clear pulse to the counter bank.
REQ-013 pc_counter_sel  output  COUNTER_COUNT  one-hot counter select.
REQ-014 pc_count_value  input  COUNTER_WIDTH  selected counter value, combinational from the bank.
REQ-015 out_valid / out_ready  output / input  1 / 1  sample record handshake.
REQ-016 out_index / out_value / out_last  output  IDX_W / COUNTER_WIDTH / 1  counter index, captured value, last record of a scan.
REQ-017 busy  output  1  high in every state except IDLE.
REQ-018 overrun  output  1  sticky flag: a tick was dropped; cleared by start.

Function
REQ-019 SHALL implement states IDLE, WAIT, CAP, OUT, CLR.
REQ-020 IDLE: start=1 and stop=0 -> WAIT; timer loads max(period,1)-1; pc_enable=1 from the next cycle.
REQ-021 Timer SHALL decrement every cycle outside IDLE; when it is 0, tick asserts for that cycle and the timer reloads max(period,1)-1, so period=0 behaves as period=1.
REQ-022 WAIT: tick -> CAP with idx=0.
REQ-023 CAP: pc_counter_sel=one-hot(idx); pc_count_value is registered into out_value, idx into out_index, and (idx==COUNTER_COUNT-1) into out_last; the next state is OUT.
REQ-024 OUT: out_valid=1, pc_counter_sel held; out_index/out_value/out_last SHALL stay stable until out_valid && out_ready.
REQ-025 OUT handshake with idx<COUNTER_COUNT-1 -> idx+1, CAP; with last: clear_on_sample=1 -> CLR, else WAIT.
REQ-026 CLR: pc_clear=1 for exactly one cycle -> WAIT.
REQ-027 pc_counter_sel SHALL be all-zero outside CAP and OUT; out_valid SHALL be 0 outside OUT.
REQ-028 A tick occurring in CAP, OUT or CLR SHALL be dropped and SHALL set overrun; the scan continues unaffected.
REQ-029 stop SHALL deassert pc_enable the next cycle and freeze the timer, and no further tick is generated.
REQ-030 stop in WAIT -> IDLE next cycle.
REQ-031 stop in CAP/OUT/CLR: the scan, including any CLR, completes, then the block enters IDLE.
REQ-032 start while not IDLE SHALL be ignored; start and stop in the same cycle: stop wins.
REQ-033 idx SHALL never exceed COUNTER_COUNT-1, and at most one record per counter is emitted per scan.

Reset
REQ-034 rst_n=0 SHALL force IDLE, idx=0, timer=0 and overrun=0, and SHALL drive pc_enable, pc_clear, pc_counter_sel, out_valid, out_index, out_value, out_last and busy to 0, asynchronously.
REQ-035 Reset mid-scan SHALL abort the scan without emitting a pc_clear pulse; the first record after release requires a new start.

Verification
REQ-036 COUNTER_COUNT=4, period=10, out_ready=1, start -> first CAP 10 cycles after start; 4 records, idx 0..3, out_last only on idx 3; scans repeat every 10 cycles.
REQ-037 clear_on_sample=1, counter 2 value 5 -> record (2,5); pc_clear pulses one cycle after the idx-3 handshake; the next scan reads 0 when no events occur.
REQ-038 out_ready held 0 for 20 cycles with period=4 -> out_value/out_index stable throughout; overrun=1; the scan resumes on out_ready=1.
REQ-039 stop during OUT idx 1 -> pc_enable=0 next cycle; records 1..3 still emitted; then IDLE, busy=0, no further records.
REQ-040 period=0 -> tick every cycle; overrun sets during the first scan; start and stop together in IDLE -> block stays IDLE.
REQ-041 rst_n asserted in OUT -> all outputs 0 immediately; no pc_clear pulse; after release and start, scans run normally from idx 0.
